gemm_core: RTL and testbench



---
 rtl/gemm_core.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_gemm_core.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_core.sv
// gemm_core: executes one 128-bit GEMM instruction as an iter_out x iter_in x uop loop nest.
// Each micro-op costs four cycles (FETCH, INDEX, MAC, WRITE) and does a 1x16 by 16x16 signed MAC.
module gemm_core #(
   parameter int UOP_WIDTH = 32,
   parameter int UPC_WIDTH = 13,
   parameter int INS_WIDTH = 128,
   parameter int INP_WIDTH = 8,
   parameter int WGT_WIDTH = 8,
   parameter int ACC_WIDTH = 32,
   parameter int INP_DEPTH = 16,
   parameter int WGT_DEPTH = 256,
   parameter int ACC_DEPTH = 16
) (
   input  logic                             ap_clk,
   input  logic                             ap_rst,
   input  logic                             ap_ce,
   input  logic                             ap_start,
   input  logic                             ap_continue,
   output logic                             ap_idle,
   output logic                             ap_done,
   output logic                             ap_ready,
   input  logic [INS_WIDTH-1:0]             insn,
   input  logic [UOP_WIDTH-1:0]             uop,
   output logic                             uop_ce,
   output logic [UPC_WIDTH-1:0]             upc,
   output logic [11:0]                      acc_mem_rd_addr,
   output logic                             acc_mem_rd_ce,
   output logic [63:0]                      acc_mem_rd_we,
   output logic [ACC_WIDTH*ACC_DEPTH-1:0]   acc_mem_rd_data_out,
   input  logic [ACC_WIDTH*ACC_DEPTH-1:0]   acc_mem_rd_data_in,
   output logic [11:0]                      acc_mem_wr_addr,
   output logic                             acc_mem_wr_ce,
   output logic [63:0]                      acc_mem_wr_we,
   output logic [ACC_WIDTH*ACC_DEPTH-1:0]   acc_mem_wr_data_out,
   input  logic [ACC_WIDTH*ACC_DEPTH-1:0]   acc_mem_wr_data_in,
   input  logic [INP_WIDTH*INP_DEPTH-1:0]   inp_mem_rd_data,
   output logic                             inp_mem_rd_ce,
   output logic [31:0]                      inp_mem_rd_addr,
   input  logic [WGT_WIDTH*WGT_DEPTH-1:0]   wgt_mem_rd_data,
   output logic                             wgt_mem_rd_ce,
   output logic [31:0]                      wgt_mem_rd_addr,
   output logic [31:0]                      out_mem_wr_addr,
   output logic                             out_mem_wr_ce,
   output logic [INP_WIDTH*INP_DEPTH-1:0]   out_mem_wr_data,
   output logic [31:0]                      out_mem_wr_we
);

   localparam int PRD_W   = INP_WIDTH + WGT_WIDTH;
   localparam int ACC_MEM = ACC_WIDTH * ACC_DEPTH;
   localparam int OUT_MEM = INP_WIDTH * INP_DEPTH;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_INDEX = 3'd2,
      S_MAC   = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t state, state_nx;

   // Latched instruction fields
   logic        rr_q;
   logic [12:0] bgn_q;
   logic [13:0] end_q;
   logic [13:0] iter_out_q, iter_in_q;
   logic [10:0] dst_out_q, dst_in_q, src_out_q, src_in_q;
   logic [9:0]  wgt_out_q, wgt_in_q;

   // Loop counters and running index offsets
   logic [13:0] i_q, j_q;
   logic [12:0] upc_q;
   logic [10:0] dst_row_q, src_row_q, dst_off_q, src_off_q;
   logic [9:0]  wgt_row_q, wgt_off_q;

   logic [10:0]        dst_q;
   logic [ACC_MEM-1:0] acc_q;
   logic [ACC_MEM-1:0] acc_new;
   logic [OUT_MEM-1:0] out_vec;

   logic        no_iter;
   logic        upc_last, j_last, i_last, last_uop;
   logic [10:0] dst_idx, src_idx;
   logic [9:0]  wgt_idx;
   logic        unused_ok;

   assign unused_ok = ^{ap_continue, acc_mem_wr_data_in, insn[6:3], insn[INS_WIDTH-1:127]};

   assign no_iter = (insn[2:0] != 3'd2) || (insn[48:35] == 14'd0) || (insn[62:49] == 14'd0) ||
                    (insn[34:21] <= {1'b0, insn[20:8]});

   assign upc_last = ({1'b0, upc_q} + 14'd1) >= end_q;
   assign j_last   = ({1'b0, j_q} + 15'd1) >= {1'b0, iter_in_q};
   assign i_last   = ({1'b0, i_q} + 15'd1) >= {1'b0, iter_out_q};
   assign last_uop = upc_last && j_last && i_last;

   // Indices wrap at their field width
   assign dst_idx = uop[10:0]  + dst_off_q;
   assign src_idx = uop[21:11] + src_off_q;
   assign wgt_idx = uop[31:22] + wgt_off_q;

   assign acc_mem_rd_we       = '0;
   assign acc_mem_rd_data_out = '0;

   // State register
   always_ff @(posedge ap_clk or negedge ap_rst) begin
      if (!ap_rst) begin
         state <= S_IDLE;
      end else if (ap_ce) begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (ap_start) state_nx = no_iter ? S_DONE : S_FETCH;
         S_FETCH: state_nx = S_INDEX;
         S_INDEX: state_nx = S_MAC;
         S_MAC:   state_nx = S_WRITE;
         S_WRITE: state_nx = last_uop ? S_DONE : S_FETCH;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath registers: instruction latch, loop walk, index and accumulator staging
   always_ff @(posedge ap_clk or negedge ap_rst) begin
      if (!ap_rst) begin
         rr_q       <= 1'b0;
         bgn_q      <= '0;
         end_q      <= '0;
         iter_out_q <= '0;
         iter_in_q  <= '0;
         dst_out_q  <= '0;
         dst_in_q   <= '0;
         src_out_q  <= '0;
         src_in_q   <= '0;
         wgt_out_q  <= '0;
         wgt_in_q   <= '0;
         i_q        <= '0;
         j_q        <= '0;
         upc_q      <= '0;
         dst_row_q  <= '0;
         src_row_q  <= '0;
         wgt_row_q  <= '0;
         dst_off_q  <= '0;
         src_off_q  <= '0;
         wgt_off_q  <= '0;
         dst_q      <= '0;
         acc_q      <= '0;
      end else if (ap_ce) begin
         case (state)
            S_IDLE: begin
               if (ap_start) begin
                  rr_q       <= insn[7];
                  bgn_q      <= insn[20:8];
                  end_q      <= insn[34:21];
                  iter_out_q <= insn[48:35];
                  iter_in_q  <= insn[62:49];
                  dst_out_q  <= insn[73:63];
                  dst_in_q   <= insn[84:74];
                  src_out_q  <= insn[95:85];
                  src_in_q   <= insn[106:96];
                  wgt_out_q  <= insn[116:107];
                  wgt_in_q   <= insn[126:117];
                  upc_q      <= insn[20:8];
                  i_q        <= '0;
                  j_q        <= '0;
                  dst_row_q  <= '0;
                  src_row_q  <= '0;
                  wgt_row_q  <= '0;
                  dst_off_q  <= '0;
                  src_off_q  <= '0;
                  wgt_off_q  <= '0;
               end
            end
            S_INDEX: dst_q <= dst_idx;
            S_MAC:   acc_q <= rr_q ? '0 : acc_new;
            S_WRITE: begin
               if (!upc_last) begin
                  upc_q <= upc_q + 13'd1;
               end else begin
                  upc_q <= bgn_q;
                  if (!j_last) begin
                     j_q       <= j_q + 14'd1;
                     dst_off_q <= dst_off_q + dst_in_q;
                     src_off_q <= src_off_q + src_in_q;
                     wgt_off_q <= wgt_off_q + wgt_in_q;
                  end else begin
                     j_q       <= '0;
                     i_q       <= i_q + 14'd1;
                     dst_row_q <= dst_row_q + dst_out_q;
                     src_row_q <= src_row_q + src_out_q;
                     wgt_row_q <= wgt_row_q + wgt_out_q;
                     dst_off_q <= dst_row_q + dst_out_q;
                     src_off_q <= src_row_q + src_out_q;
                     wgt_off_q <= wgt_row_q + wgt_out_q;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Matrix-vector MAC: 16-bit signed products, sign-extended and summed modulo 2^ACC_WIDTH
   always_comb begin
      logic [ACC_WIDTH-1:0]       sum;
      logic signed [INP_WIDTH-1:0] a;
      logic signed [WGT_WIDTH-1:0] b;
      logic signed [PRD_W-1:0]     ax, bx, prod;
      acc_new = '0;
      sum     = '0;
      a       = '0;
      b       = '0;
      ax      = '0;
      bx      = '0;
      prod    = '0;
      for (int k = 0; k < ACC_DEPTH; k++) begin
         sum = acc_mem_rd_data_in[ACC_WIDTH*k +: ACC_WIDTH];
         for (int m = 0; m < INP_DEPTH; m++) begin
            a    = inp_mem_rd_data[INP_WIDTH*m +: INP_WIDTH];
            b    = wgt_mem_rd_data[WGT_WIDTH*(INP_DEPTH*k + m) +: WGT_WIDTH];
            ax   = PRD_W'(a);
            bx   = PRD_W'(b);
            prod = ax * bx;
            sum  = sum + {{(ACC_WIDTH-PRD_W){prod[PRD_W-1]}}, prod};
         end
         acc_new[ACC_WIDTH*k +: ACC_WIDTH] = sum;
      end
   end

   always_comb begin
      out_vec = '0;
      for (int k = 0; k < ACC_DEPTH; k++) begin
         out_vec[INP_WIDTH*k +: INP_WIDTH] = acc_q[ACC_WIDTH*k +: INP_WIDTH];
      end
   end

   // Outputs decode from held state, so they freeze with ap_ce.
   // Handshake: ap_start is taken in IDLE in the cycle ap_ready is high; ap_done pulses once per instruction.
   always_comb begin
      ap_idle             = 1'b0;
      ap_done             = 1'b0;
      ap_ready            = 1'b0;
      uop_ce              = 1'b0;
      upc                 = '0;
      acc_mem_rd_addr     = '0;
      acc_mem_rd_ce       = 1'b0;
      inp_mem_rd_addr     = '0;
      inp_mem_rd_ce       = 1'b0;
      wgt_mem_rd_addr     = '0;
      wgt_mem_rd_ce       = 1'b0;
      acc_mem_wr_addr     = '0;
      acc_mem_wr_ce       = 1'b0;
      acc_mem_wr_we       = '0;
      acc_mem_wr_data_out = '0;
      out_mem_wr_addr     = '0;
      out_mem_wr_ce       = 1'b0;
      out_mem_wr_data     = '0;
      out_mem_wr_we       = '0;
      case (state)
         S_IDLE: begin
            ap_idle  = 1'b1;
            ap_ready = ap_start && ap_ce;
         end
         S_FETCH: begin
            uop_ce = 1'b1;
            upc    = upc_q;
         end
         S_INDEX: begin
            if (!rr_q) begin
               acc_mem_rd_ce   = 1'b1;
               inp_mem_rd_ce   = 1'b1;
               wgt_mem_rd_ce   = 1'b1;
               acc_mem_rd_addr = {1'b0, dst_idx};
               inp_mem_rd_addr = {19'd0, src_idx, 2'b00};
               wgt_mem_rd_addr = {20'd0, wgt_idx, 2'b00};
            end
         end
         S_WRITE: begin
            acc_mem_wr_ce       = 1'b1;
            acc_mem_wr_addr     = {1'b0, dst_q};
            acc_mem_wr_we       = '1;
            acc_mem_wr_data_out = acc_q;
            out_mem_wr_ce       = 1'b1;
            out_mem_wr_addr     = {19'd0, dst_q, 2'b00};
            out_mem_wr_data     = out_vec;
            out_mem_wr_we       = '1;
         end
         S_DONE: ap_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_gemm_core.sv
// tb_gemm_core: directed GEMM instructions against single-cycle memory models;
// expected writes go into a scoreboard queue that a negedge monitor drains.
module tb_gemm_core;

   logic          clk = 1'b0;
   logic          ap_rst, ap_ce, ap_start, ap_continue;
   logic          ap_idle, ap_done, ap_ready;
   logic [127:0]  insn;
   logic [31:0]   uop_rd;
   logic          uop_ce;
   logic [12:0]   upc;
   logic [11:0]   acc_mem_rd_addr, acc_mem_wr_addr;
   logic          acc_mem_rd_ce, acc_mem_wr_ce;
   logic [63:0]   acc_mem_rd_we, acc_mem_wr_we;
   logic [511:0]  acc_mem_rd_data_out, acc_rd, acc_mem_wr_data_out;
   logic [511:0]  acc_mem_wr_data_in;
   logic [127:0]  inp_rd, out_mem_wr_data;
   logic          inp_mem_rd_ce, wgt_mem_rd_ce, out_mem_wr_ce;
   logic [31:0]   inp_mem_rd_addr, wgt_mem_rd_addr, out_mem_wr_addr, out_mem_wr_we;
   logic [2047:0] wgt_rd;

   logic [31:0]   uop_mem [0:3];
   logic [511:0]  acc_mem [0:15];
   logic [127:0]  inp_mem [0:7];
   logic [2047:0] wgt_mem [0:3];

   logic [10:0]   exp_addr_q[$];
   logic [511:0]  exp_acc_q[$];
   logic [127:0]  exp_out_q[$];
   logic [10:0]   mon_addr;
   logic [511:0]  mon_acc;
   logic [127:0]  mon_out;

   int cyc = 0;
   int chk_cnt = 0, pass_cnt = 0;
   int done_cnt = 0, wr_cnt = 0, rd_cnt = 0, traffic_cnt = 0;
   int ready_cyc = 0, done_cyc = 0, fetch_cyc = 0, wr_cyc = 0;

   gemm_core dut (
      .ap_clk(clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .ap_start(ap_start),
      .ap_continue(ap_continue), .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready),
      .insn(insn), .uop(uop_rd), .uop_ce(uop_ce), .upc(upc),
      .acc_mem_rd_addr(acc_mem_rd_addr), .acc_mem_rd_ce(acc_mem_rd_ce),
      .acc_mem_rd_we(acc_mem_rd_we), .acc_mem_rd_data_out(acc_mem_rd_data_out),
      .acc_mem_rd_data_in(acc_rd),
      .acc_mem_wr_addr(acc_mem_wr_addr), .acc_mem_wr_ce(acc_mem_wr_ce),
      .acc_mem_wr_we(acc_mem_wr_we), .acc_mem_wr_data_out(acc_mem_wr_data_out),
      .acc_mem_wr_data_in(acc_mem_wr_data_in),
      .inp_mem_rd_data(inp_rd), .inp_mem_rd_ce(inp_mem_rd_ce), .inp_mem_rd_addr(inp_mem_rd_addr),
      .wgt_mem_rd_data(wgt_rd), .wgt_mem_rd_ce(wgt_mem_rd_ce), .wgt_mem_rd_addr(wgt_mem_rd_addr),
      .out_mem_wr_addr(out_mem_wr_addr), .out_mem_wr_ce(out_mem_wr_ce),
      .out_mem_wr_data(out_mem_wr_data), .out_mem_wr_we(out_mem_wr_we)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-cycle-latency memory models
   always @(posedge clk) begin
      if (uop_ce)        uop_rd <= uop_mem[upc[1:0]];
      if (acc_mem_rd_ce) acc_rd <= acc_mem[acc_mem_rd_addr[3:0]];
      if (inp_mem_rd_ce) inp_rd <= inp_mem[inp_mem_rd_addr[4:2]];
      if (wgt_mem_rd_ce) wgt_rd <= wgt_mem[wgt_mem_rd_addr[3:2]];
   end

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [511:0] fill_acc(input logic [31:0] v);
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[32*k +: 32] = v;
      return r;
   endfunction

   function automatic logic [127:0] fill8(input logic [7:0] v);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = v;
      return r;
   endfunction

   function automatic logic [2047:0] ident();
      logic [2047:0] r;
      for (int k = 0; k < 16; k++)
         for (int m = 0; m < 16; m++) r[8*(16*k+m) +: 8] = (k == m) ? 8'd1 : 8'd0;
      return r;
   endfunction

   function automatic logic [127:0] mk_insn(input logic [2:0] op, input logic rr,
         input logic [12:0] bgn, input logic [13:0] uend, input logic [13:0] io, input logic [13:0] ii,
         input logic [10:0] dout, input logic [10:0] din, input logic [10:0] sout,
         input logic [10:0] sin, input logic [9:0] wout, input logic [9:0] win);
      logic [127:0] r;
      r = '0;
      r[2:0] = op;      r[6:3] = 4'b1010;  r[7] = rr;
      r[20:8] = bgn;    r[34:21] = uend;   r[48:35] = io;    r[62:49] = ii;
      r[73:63] = dout;  r[84:74] = din;    r[95:85] = sout;  r[106:96] = sin;
      r[116:107] = wout; r[126:117] = win; r[127] = 1'b1;
      return r;
   endfunction

   task automatic push_exp(input logic [10:0] a, input logic [511:0] acc, input logic [127:0] o);
      exp_addr_q.push_back(a);
      exp_acc_q.push_back(acc);
      exp_out_q.push_back(o);
   endtask

   task automatic start_insn(input logic [127:0] ins);
      @(posedge clk); #1;
      insn = ins;
      ap_start = 1'b1;
      @(posedge clk); #1;
      ap_start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int lat, input string nm);
      int t = 0;
      while (done_cnt == d0 && t < 400) begin
         @(posedge clk);
         t++;
      end
      check({nm, "_done"}, done_cnt - d0, 1);
      check({nm, "_latency"}, done_cyc - ready_cyc, lat);
   endtask

   // Monitor: sample away from the active edge, drain the scoreboard on every write
   always @(negedge clk) begin
      if (uop_ce) fetch_cyc = cyc;
      if (ap_ready) ready_cyc = cyc;
      if (ap_done) begin
         done_cyc = cyc;
         done_cnt++;
      end
      if (acc_mem_rd_ce || inp_mem_rd_ce || wgt_mem_rd_ce) rd_cnt++;
      if (uop_ce || acc_mem_rd_ce || inp_mem_rd_ce || wgt_mem_rd_ce || acc_mem_wr_ce || out_mem_wr_ce)
         traffic_cnt++;
      if (acc_mem_wr_ce || out_mem_wr_ce) begin
         wr_cnt++;
         wr_cyc = cyc;
         check("write_expected", exp_addr_q.size() != 0, 1);
         if (exp_addr_q.size() != 0) begin
            mon_addr = exp_addr_q.pop_front();
            mon_acc  = exp_acc_q.pop_front();
            mon_out  = exp_out_q.pop_front();
            check("wr_ce_pair", {acc_mem_wr_ce, out_mem_wr_ce}, 2'b11);
            check("acc_wr_addr", acc_mem_wr_addr, {1'b0, mon_addr});
            check("out_wr_addr", out_mem_wr_addr, {19'd0, mon_addr, 2'b00});
            check("acc_wr_data", acc_mem_wr_data_out, mon_acc);
            check("out_wr_data", out_mem_wr_data, mon_out);
            check("acc_wr_we", acc_mem_wr_we, {64{1'b1}});
            check("out_wr_we", out_mem_wr_we, {32{1'b1}});
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [511:0] v;
      logic [127:0] o;
      logic [127:0] t1_insn;
      int d0, w0, r0, x0;
      ap_rst = 1'b0;
      ap_ce = 1'b1;
      ap_start = 1'b0;
      ap_continue = 1'b0;
      insn = '0;
      acc_mem_wr_data_in = '0;
      for (int n = 0; n < 4; n++) begin uop_mem[n] = '0; wgt_mem[n] = '0; end
      for (int n = 0; n < 8; n++) inp_mem[n] = '0;
      for (int n = 0; n < 16; n++) acc_mem[n] = '0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_idle", ap_idle, 1'b1);
      check("rst_enables", {ap_done, ap_ready, uop_ce, acc_mem_rd_ce, inp_mem_rd_ce, wgt_mem_rd_ce,
                            acc_mem_wr_ce, out_mem_wr_ce}, 8'd0);
      check("rst_we", {acc_mem_wr_we, out_mem_wr_we, acc_mem_rd_we}, 160'd0);
      check("rst_addr", {upc, acc_mem_rd_addr, acc_mem_wr_addr, out_mem_wr_addr, inp_mem_rd_addr}, 101'd0);
      @(posedge clk); #1;
      ap_rst = 1'b1;

      // Identity weights, unit inputs, acc 5 -> 6
      uop_mem[0] = 32'd0;
      inp_mem[0] = fill8(8'd1);
      wgt_mem[0] = ident();
      acc_mem[0] = fill_acc(32'd5);
      t1_insn = mk_insn(3'd2, 1'b0, 13'd0, 14'd1, 14'd1, 14'd1, 11'd0, 11'd0, 11'd0, 11'd0, 10'd0, 10'd0);
      push_exp(11'd0, fill_acc(32'd6), fill8(8'd6));
      d0 = done_cnt;
      start_insn(t1_insn);
      wait_done(d0, 5, "t1");
      check("t1_write_after_fetch", wr_cyc - fetch_cyc, 3);

      // reset_reg over two rows: zeros at 3 and 4, no reads
      uop_mem[1] = {10'd1, 11'd5, 11'd3};
      acc_mem[3] = fill_acc(32'h1234);
      acc_mem[4] = fill_acc(32'h5678);
      push_exp(11'd3, '0, '0);
      push_exp(11'd4, '0, '0);
      d0 = done_cnt; r0 = rd_cnt;
      start_insn(mk_insn(3'd2, 1'b1, 13'd1, 14'd2, 14'd2, 14'd1, 11'd1, 11'd0, 11'd0, 11'd0, 10'd0, 10'd0));
      wait_done(d0, 9, "t2");
      check("t2_no_reads", rd_cnt - r0, 0);

      // 2x2 nest: dst 0,1,4,5 from src 0,1,2,3
      for (int s = 0; s < 4; s++)
         for (int m = 0; m < 16; m++) inp_mem[s][8*m +: 8] = 8'(16*s + m);
      acc_mem[0] = '0; acc_mem[1] = '0; acc_mem[4] = '0; acc_mem[5] = '0;
      for (int s = 0; s < 4; s++) begin
         for (int k = 0; k < 16; k++) begin
            v[32*k +: 32] = 32'(16*s + k);
            o[8*k +: 8]   = 8'(16*s + k);
         end
         push_exp((s < 2) ? 11'(s) : 11'(s + 2), v, o);
      end
      d0 = done_cnt;
      start_insn(mk_insn(3'd2, 1'b0, 13'd0, 14'd1, 14'd2, 14'd2, 11'd4, 11'd1, 11'd2, 11'd1, 10'd0, 10'd0));
      wait_done(d0, 17, "t3");

      // Extreme operands: 0x7FFFFFFF + 16*16384 wraps to 0x8003FFFF
      uop_mem[2] = {10'd2, 11'd6, 11'd7};
      inp_mem[6] = fill8(8'h80);
      wgt_mem[2] = {256{8'h80}};
      acc_mem[7] = fill_acc(32'h7FFFFFFF);
      push_exp(11'd7, fill_acc(32'h8003FFFF), fill8(8'hFF));
      d0 = done_cnt;
      start_insn(mk_insn(3'd2, 1'b0, 13'd2, 14'd3, 14'd1, 14'd1, 11'd0, 11'd0, 11'd0, 11'd0, 10'd0, 10'd0));
      wait_done(d0, 5, "t4");

      // Empty uop range and non-GEMM opcode: ready then done, no traffic
      d0 = done_cnt; x0 = traffic_cnt;
      start_insn(mk_insn(3'd2, 1'b0, 13'd3, 14'd3, 14'd1, 14'd1, 11'd0, 11'd0, 11'd0, 11'd0, 10'd0, 10'd0));
      wait_done(d0, 1, "t5_empty");
      check("t5_empty_traffic", traffic_cnt - x0, 0);
      d0 = done_cnt; x0 = traffic_cnt;
      start_insn(mk_insn(3'd0, 1'b0, 13'd0, 14'd1, 14'd1, 14'd1, 11'd0, 11'd0, 11'd0, 11'd0, 10'd0, 10'd0));
      wait_done(d0, 1, "t5_opcode");
      check("t5_opcode_traffic", traffic_cnt - x0, 0);

      // Clock enable low for 3 cycles mid-run: same result, 3 cycles later
      acc_mem[0] = fill_acc(32'd5);
      inp_mem[0] = fill8(8'd1);
      push_exp(11'd0, fill_acc(32'd6), fill8(8'd6));
      d0 = done_cnt;
      start_insn(t1_insn);
      ap_ce = 1'b0;
      repeat (3) @(posedge clk);
      #1 ap_ce = 1'b1;
      wait_done(d0, 8, "t5_ce");

      // Reset during MAC aborts without writing
      d0 = done_cnt; w0 = wr_cnt;
      start_insn(t1_insn);
      @(posedge clk);
      @(posedge clk); #1;
      ap_rst = 1'b0;
      @(negedge clk);
      check("t6_idle_in_reset", ap_idle, 1'b1);
      check("t6_no_wr_in_reset", {acc_mem_wr_ce, out_mem_wr_ce}, 2'b00);
      @(posedge clk); #1;
      ap_rst = 1'b1;
      repeat (8) @(posedge clk);
      check("t6_no_write", wr_cnt - w0, 0);
      check("t6_no_done", done_cnt - d0, 0);
      push_exp(11'd0, fill_acc(32'd6), fill8(8'd6));
      d0 = done_cnt;
      start_insn(t1_insn);
      wait_done(d0, 5, "t6_rerun");

      repeat (5) @(posedge clk);
      check("sb_drained", exp_addr_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
